// File: rtl/axi_burst_sink.sv
// AXI3 write-only burst sink: INCR bursts into an internal word memory, one B per burst,
// registered readback port and saturating counters. Optional macro: AXI_SINK_WID_CHECK_EN.
module axi_burst_sink #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [3:0]                   awid_i,
  input  logic [ADDR_WIDTH-1:0]        awaddr_i,
  input  logic [3:0]                   awlen_i,
  input  logic [2:0]                   awsize_i,
  input  logic [1:0]                   awburst_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [3:0]                   wid_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [3:0]                   wstrb_i,
  input  logic                         wlast_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  output logic [3:0]                   bid_o,
  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic [CNT_WIDTH-1:0]         burst_cnt_o,
  output logic [CNT_WIDTH-1:0]         beat_cnt_o,
  output logic [CNT_WIDTH-1:0]         err_cnt_o
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [3:0]            r_id;
  logic [3:0]            r_len;
  logic [3:0]            r_beat;
  logic [IdxW-1:0]       r_idx;
  logic                  r_wrap;
  logic [1:0]            r_status;
  logic [CNT_WIDTH-1:0]  r_burst_cnt;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;
  logic [CNT_WIDTH-1:0]  r_err_cnt;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic       w_awready;
  logic       w_wready;
  logic       w_bvalid;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_b_hs;
  logic       w_len_hit;
  logic       w_aw_oor;
  logic [1:0] w_aw_status;
  logic [1:0] w_beat_status;
  logic       w_wr_en;

  assign w_aw_hs   = awvalid_i & w_awready;
  assign w_w_hs    = wvalid_i & w_wready;
  assign w_b_hs    = bready_i & w_bvalid;
  assign w_len_hit = (r_beat == r_len);
  assign w_aw_oor  = |awaddr_i[ADDR_WIDTH-1:2+IdxW];

  always_comb begin
    w_aw_status = RespOkay;
    if (w_aw_oor) begin
      w_aw_status = RespDecErr;
    end else if (awsize_i != 3'b010 || awburst_i != 2'b01) begin
      w_aw_status = RespSlvErr;
    end
  end

  // Writes use the status held before this beat; the beat's own errors only affect later beats.
  always_comb begin
    w_beat_status = r_status;
    w_wr_en       = w_w_hs && (r_status == RespOkay) && !r_wrap;
    if (w_w_hs) begin
      if (r_wrap) begin
        w_beat_status = RespDecErr;
      end
`ifdef AXI_SINK_WID_CHECK_EN
      if (wid_i != r_id && w_beat_status != RespDecErr) begin
        w_beat_status = RespSlvErr;
      end
`endif
      if ((wlast_i != w_len_hit) && w_beat_status != RespDecErr) begin
        w_beat_status = RespSlvErr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_bvalid    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_awready = 1'b1;
        if (w_aw_hs) begin
          w_state_nxt = StData;
        end
      end
      StData: begin
        w_wready = 1'b1;
        if (w_w_hs && (wlast_i || w_len_hit)) begin
          w_state_nxt = StResp;
        end
      end
      StResp: begin
        w_bvalid = 1'b1;
        if (w_b_hs) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_id        <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_idx       <= '0;
      r_wrap      <= 1'b0;
      r_status    <= RespOkay;
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
      r_err_cnt   <= '0;
      r_rd_data   <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr_i];
      if (w_aw_hs) begin
        r_id     <= awid_i;
        r_len    <= awlen_i;
        r_beat   <= '0;
        r_idx    <= awaddr_i[2 +: IdxW];
        r_wrap   <= 1'b0;
        r_status <= w_aw_status;
      end
      if (w_w_hs) begin
        r_beat   <= r_beat + 4'd1;
        r_idx    <= r_idx + 1'b1;
        r_status <= w_beat_status;
        if (r_idx == IdxW'(MEM_DEPTH - 1)) begin
          r_wrap <= 1'b1;
        end
        if (r_beat_cnt != '1) begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
      if (w_b_hs) begin
        if (r_burst_cnt != '1) begin
          r_burst_cnt <= r_burst_cnt + 1'b1;
        end
        if (r_status != RespOkay && r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  // Storage is never cleared; reset only blocks a write on the same edge.
  always_ff @(posedge clk) begin
    if (!areset && w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) begin
          r_mem[r_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

`ifdef AXI_SINK_WID_CHECK_EN
  logic w_unused;
  assign w_unused = ^awaddr_i[1:0];
`else
  logic w_unused;
  assign w_unused = ^{awaddr_i[1:0], wid_i};
`endif

  assign awready_o   = w_awready;
  assign wready_o    = w_wready;
  assign bvalid_o    = w_bvalid;
  assign bid_o       = r_id;
  assign bresp_o     = r_status;
  assign rd_data_o   = r_rd_data;
  assign burst_cnt_o = r_burst_cnt;
  assign beat_cnt_o  = r_beat_cnt;
  assign err_cnt_o   = r_err_cnt;

endmodule
